// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch unit: FSM state encoding, instruction size
// and the default reset vector.
package pc_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        HALT = 2'd3
    } fetch_state_e;

    localparam int unsigned INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: asynchronous active-high reset to RESET_VECTOR and a
// load enable.
module pc_reg
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_en,
    input  logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_q
);

    // PC storage, loaded only when the fetch FSM asks for it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else if (load_en) begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one request at a time and hands the
// tagged instruction to decode. Macro PC_MISALIGN_TRAP_EN enables the misalign trap.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            dec_ready,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic            misalign_err
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSTR_BYTES - 1);

    fetch_state_e    state_q, state_d;
    logic            req_valid_q, req_valid_d;
    logic            squash_q, squash_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            instr_valid_q, instr_valid_d;
    logic [XLEN-1:0] instr_data_q, instr_data_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_load;
    logic            req_fire;
    logic            redirect_bad;
    logic            redirect_ok;
    logic [XLEN-1:0] redirect_pc;

`ifdef PC_MISALIGN_TRAP_EN
    assign redirect_bad = redirect_valid & ((redirect_target & ALIGN_MASK) != '0);
    assign redirect_pc  = redirect_target;
`else
    assign redirect_bad = 1'b0;
    assign redirect_pc  = redirect_target & ~ALIGN_MASK;
`endif

    assign redirect_ok = redirect_valid & ~redirect_bad;
    assign req_fire    = req_valid_q & imem_req_ready;

    pc_reg #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (pc_load),
        .pc_d    (pc_d),
        .pc_q    (pc_q)
    );

    // Fetch FSM next-state; a redirect outranks dec_ready and memory responses
    always_comb begin
        state_d       = state_q;
        squash_d      = squash_q;
        req_pc_d      = req_pc_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        misalign_d    = misalign_q;
        pc_d          = pc_q;
        pc_load       = 1'b0;

        case (state_q)
            REQ: begin
                if (redirect_ok) begin
                    pc_d          = redirect_pc;
                    pc_load       = 1'b1;
                    instr_valid_d = 1'b0;
                    if (req_fire) begin
                        // memory already took the old address; its reply must be dropped
                        state_d  = WAIT;
                        squash_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end else if (req_fire) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    pc_load  = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (redirect_ok) begin
                    pc_d          = redirect_pc;
                    pc_load       = 1'b1;
                    instr_valid_d = 1'b0;
                    if (imem_resp_valid) begin
                        state_d  = REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        instr_data_d  = imem_resp_data;
                        instr_pc_d    = req_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                if (redirect_ok) begin
                    pc_d          = redirect_pc;
                    pc_load       = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end else if (dec_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            HALT: begin
                state_d       = HALT;
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (redirect_bad && (state_q != HALT)) begin
            state_d       = HALT;
            misalign_d    = 1'b1;
            instr_valid_d = 1'b0;
            squash_d      = 1'b0;
            pc_load       = 1'b0;
        end else begin
            misalign_d = misalign_q;
        end
    end

    assign req_valid_d = (state_d == REQ);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= REQ;
            req_valid_q   <= 1'b0;
            squash_q      <= 1'b0;
            req_pc_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            squash_q      <= squash_d;
            req_pc_q      <= req_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign instr_valid    = instr_valid_q;
    assign instr_data     = instr_data_q;
    assign instr_pc       = instr_pc_q;
    assign misalign_err   = misalign_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter (PC) and issues instruction-fetch requests to instruction memory over a valid/ready request and valid response interface.
- Delivers fetched instructions, tagged with their PC, to decode.
- Sits between instruction memory and decode and is the sole owner of the PC register.
- Supports decode stall and branch/jump redirect, with squash of an in-flight fetch.

Parameters:
- XLEN, 32, width of PC, addresses and instruction words.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  XLEN  fetch address (= PC).
- imem_resp_valid  in  1  response data valid; at most one outstanding request.
- imem_resp_data  in  XLEN  instruction word.
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_target  in  XLEN  new PC.
- dec_ready  in  1  decode can accept an instruction.
- instr_valid  out  1  instruction to decode valid.
- instr_data  out  XLEN  instruction word.
- instr_pc  out  XLEN  PC of instr_data.
- misalign_err  out  1  misaligned redirect detected (see Optional Feature).

Behaviour:
- Reset and clocking: one clock domain. rst is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: pc = RESET_VECTOR, state = REQ, imem_req_valid = 0, instr_valid = 0, instr_data = 0, instr_pc = 0, misalign_err = 0, squash = 0.
- imem_req_valid rises in the first cycle after rst deasserts.
- State REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - On imem_req_ready: go to WAIT; record req_pc = pc; pc <= pc + 4.
  - Address, valid and pc stay stable until accepted.
- State WAIT:
  - imem_req_valid = 0.
  - On imem_resp_valid with squash = 0: register instr_data = resp_data, instr_pc = req_pc, instr_valid = 1; go to HOLD.
  - On imem_resp_valid with squash = 1: discard the data, clear squash, go to REQ.
- State HOLD:
  - instr_valid = 1; outputs held stable.
  - On dec_ready: instr_valid <= 0 and go to REQ next cycle.
  - Fetch-to-decode latency: minimum 2 cycles from request acceptance when memory responds in 1 cycle. Throughput: 1 instruction per 3 cycles.
- Redirect (redirect_valid = 1), any state:
  - pc <= redirect_target.
  - instr_valid <= 0 (drops any held instruction).
  - In REQ: the current request is withdrawn whether or not imem_req_ready is high that cycle. If the request was accepted in the same cycle, set squash and go to WAIT; otherwise stay in REQ with the new address next cycle.
  - In WAIT: set squash; a response arriving in the same cycle is discarded and the state goes to REQ.
  - In HOLD: go to REQ.
- Redirect takes priority over dec_ready and over imem_resp_valid in the same cycle.
- Arithmetic: pc + 4 is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no error.
- Unexpected imem_resp_valid in REQ or HOLD is ignored.
- Reset asserted mid-WAIT: state returns to REQ; a memory response arriving after reset is ignored because the state is REQ.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_target[1:0] != 0 does not load pc and sets misalign_err = 1 (sticky).
  - The unit enters state HALT: no requests, instr_valid = 0. Only rst exits HALT.
  - An aligned redirect in the same cycle as a misaligned one cannot occur, since there is one redirect port.
- Undefined:
  - redirect_target is loaded with bits [1:0] forced to 0.
  - misalign_err is tied to 0 and the HALT state does not exist.

Decomposition:
- Shared package pc_pkg:
  - state encoding enum {REQ, WAIT, HOLD, HALT}.
  - INSTR_BYTES = 4.
  - default RESET_VECTOR constant.
- Sub-module: pc_reg, a parameterised XLEN-wide register with asynchronous active-high reset to RESET_VECTOR and load-enable, holding pc. The fetch state machine and output register stay in pc_fetch_unit.

Test Plan:
- Reset, memory always ready, 1-cycle response, dec_ready = 1 → requests issued to 0x0, 0x4, 0x8; instr_pc matches each; instr_valid pulses every 3 cycles.
- dec_ready held 0 for 5 cycles in HOLD → instr_data/instr_pc stable, no new request; dec_ready = 1 → next request addresses instr_pc + 4.
- redirect_valid with target 0x100 while in WAIT; response 0xDEADBEEF arrives 2 cycles later → 0xDEADBEEF never appears on instr_valid; next request addresses 0x100.
- imem_req_ready held 0 for 4 cycles → imem_req_addr constant, pc not incremented; redirect to 0x40 in cycle 3 → addr becomes 0x40 next cycle.
- pc preloaded via redirect to 0xFFFF_FFFC, then fetch → following request addresses 0x0000_0000.
- rst asserted asynchronously mid-WAIT, then 0x200 redirect with target 0x102:
  - Reset → all outputs return to their reset values immediately.
  - With PC_MISALIGN_TRAP_EN: misalign_err = 1 and no further requests.
  - Without it: next request addresses 0x100.
